// File: rtl/exec_writeback_ctrl.sv
// exec_writeback_ctrl: multi-cycle fetch/decode/execute/writeback sequencer
// for the 8-bit li/addi datapath. Owns the PC, fetches 16-bit instructions
// over a req/ack port and drives the datapath controls and the write strobe.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Start                 run request (honoured in IDLE and HALT only)
//   Imem_Req/Addr/Ack/Data instruction fetch handshake (Addr = PC)
//   ALUSrc, Imm_Data, Reg_Addr  decoded datapath controls, held until next decode
//   Reg_Write             one-cycle write strobe per retired instruction
//   Busy, Halted, Illegal status (Illegal is sticky until restart)
//   Retire_Cnt            retired-instruction counter, present only when
//                         EXEC_CTRL_RETIRE_CNT_EN is defined
module exec_writeback_ctrl #(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    output logic              Imem_Req,
    output logic [PC_W-1:0]   Imem_Addr,
    input  logic              Imem_Ack,
    input  logic [15:0]       Imem_Data,
    output logic              ALUSrc,
    output logic [DATA_W-1:0] Imm_Data,
    output logic [3:0]        Reg_Addr,
    output logic              Reg_Write,
    output logic              Busy,
    output logic              Halted,
    output logic              Illegal
`ifdef EXEC_CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0]       Retire_Cnt
`endif
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned REG_W   = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [OPC_W-1:0] OPC_LI   = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ADDI = 4'h1;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

    logic [2:0]         state_q,     state_d;
    logic [PC_W-1:0]    pc_q,        pc_d;
    logic [INSTR_W-1:0] ir_q,        ir_d;
    logic               imem_req_q,  imem_req_d;
    logic               alusrc_q,    alusrc_d;
    logic [DATA_W-1:0]  imm_q,       imm_d;
    logic [REG_W-1:0]   reg_addr_q,  reg_addr_d;
    logic               reg_write_q, reg_write_d;
    logic               busy_q,      busy_d;
    logic               halted_q,    halted_d;
    logic               illegal_q,   illegal_d;

    logic [OPC_W-1:0]   opcode_c;
    assign opcode_c = ir_q[15:12];

    // Next state; registered outputs are derived from the next state so they
    // line up with the state register after each edge.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        alusrc_d   = alusrc_q;
        imm_d      = imm_q;
        reg_addr_d = reg_addr_q;
        illegal_d  = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (Imem_Ack) begin
                    ir_d    = Imem_Data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode_c)
                    OPC_LI, OPC_ADDI: begin
                        alusrc_d   = (opcode_c == OPC_ADDI);
                        imm_d      = DATA_W'(ir_q[7:0]);
                        reg_addr_d = ir_q[11:8];
                        state_d    = S_EXECUTE;
                    end
                    OPC_HALT: begin
                        illegal_d = 1'b0;
                        state_d   = S_HALT;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (Start) begin
                    illegal_d = 1'b0;
                    pc_d      = '0;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_req_d  = (state_d == S_FETCH);
        reg_write_d = (state_d == S_WRITEBACK);
        halted_d    = (state_d == S_HALT);
        busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            imem_req_q  <= 1'b0;
            alusrc_q    <= 1'b0;
            imm_q       <= '0;
            reg_addr_q  <= '0;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            imem_req_q  <= imem_req_d;
            alusrc_q    <= alusrc_d;
            imm_q       <= imm_d;
            reg_addr_q  <= reg_addr_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign Imem_Req  = imem_req_q;
    assign Imem_Addr = pc_q;
    assign ALUSrc    = alusrc_q;
    assign Imm_Data  = imm_q;
    assign Reg_Addr  = reg_addr_q;
    assign Reg_Write = reg_write_q;
    assign Busy      = busy_q;
    assign Halted    = halted_q;
    assign Illegal   = illegal_q;

`ifdef EXEC_CTRL_RETIRE_CNT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Counts write strobes; survives restart, cleared only by reset.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (reg_write_d) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) retire_cnt_q <= '0;
        else          retire_cnt_q <= retire_cnt_d;
    end

    assign Retire_Cnt = retire_cnt_q;
`endif

endmodule
